// File: rtl/acc_result_fifo.sv
// acc_result_fifo: capture stage behind the add/subtract accumulator.
//
// A capture strobe samples {overflow, carry, S} as one record into a small
// first-word-fall-through FIFO. A valid/ready consumer drains the FIFO. The
// block also keeps sticky carry/overflow flags and a saturating count of
// records lost because the FIFO was full.
//
// Ports:
//   clk          system clock, rising edge
//   aclr_n       asynchronous active-low reset
//   cap          capture strobe for S/carry/overflow
//   S            accumulator result (N bits)
//   carry        accumulator carry/borrow
//   overflow     accumulator overflow
//   clr_sticky   synchronous clear of the sticky flags
//   rd_ready     consumer accepts rd_data this cycle
//   rd_valid     FIFO non-empty, rd_data is valid
//   rd_data      head record {overflow, carry, S}
//   full/empty   level == DEPTH / level == 0
//   level        number of stored records
//   sticky_ovf   set by any captured overflow
//   sticky_carry set by any captured carry
//   drop_cnt     saturating count of records dropped while full
module acc_result_fifo #(
  parameter int unsigned N     = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 8
) (
  input  logic                       clk,
  input  logic                       aclr_n,
  input  logic                       cap,
  input  logic [N-1:0]               S,
  input  logic                       carry,
  input  logic                       overflow,
  input  logic                       clr_sticky,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [N+1:0]               rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       sticky_ovf,
  output logic                       sticky_carry,
  output logic [CW-1:0]              drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [N+1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] level_q;
  logic          sticky_ovf_q, sticky_carry_q;
  logic [CW-1:0] drop_cnt_q;

  logic push, pop, drop;

  // Status is decoded from the level register only; pointer equality is
  // ambiguous once the pointers wrap.
  assign empty    = (level_q == '0);
  assign full     = (level_q == LW'(DEPTH));
  assign rd_valid = ~empty;
  assign level    = level_q;

  assign pop  = rd_valid & rd_ready;
  // A pop in the same cycle frees the slot, so a capture while full is kept.
  assign push = cap & (~full | pop);
  assign drop = cap & full & ~pop;

  // First-word fall-through: head comes straight from storage.
  assign rd_data = mem_q[rptr_q];

  // Storage needs no reset; its contents are ignored while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= {overflow, carry, S};
    end
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      if (push && !pop) begin
        level_q <= level_q + LW'(1);
      end else if (pop && !push) begin
        level_q <= level_q - LW'(1);
      end
    end
  end

  // Sticky flags: a capture in the same cycle as clr_sticky still sets them.
  // Dropped records update the flags too.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      sticky_ovf_q   <= 1'b0;
      sticky_carry_q <= 1'b0;
    end else if (clr_sticky) begin
      sticky_ovf_q   <= cap & overflow;
      sticky_carry_q <= cap & carry;
    end else if (cap) begin
      sticky_ovf_q   <= sticky_ovf_q | overflow;
      sticky_carry_q <= sticky_carry_q | carry;
    end
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      drop_cnt_q <= '0;
    end else if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_q <= drop_cnt_q + CW'(1);
    end
  end

  assign sticky_ovf   = sticky_ovf_q;
  assign sticky_carry = sticky_carry_q;
  assign drop_cnt     = drop_cnt_q;

endmodule
